fmul_share_arbiter: RTL and testbench
=====================================

Name: fmul_share_arbiter

Overview:
Shares one single-precision floating-point multiplier (registered output, fixed pipeline latency) between NUM_REQ requesters. Arbitration is round-robin. One operation issues per cycle at most. The arbiter tracks requester IDs through the multiplier pipeline and returns each product, tagged with its ID, to the originating requester. It sits between the FPU front-end issue ports and the shared multiplier instance; the multiplier itself stays outside this block.

Parameters:
WIDTH, 32, operand/product width (IEEE-754 single)
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index, = clog2(NUM_REQ)
MUL_LAT, 1, cycles from mul_a/mul_b valid to mul_product valid (multiplier's internal register stages, >=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-requester request; operands must be valid while high
req_a  input  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  packed operand B, same packing
gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
mul_a  output  WIDTH  registered operand A to shared multiplier
mul_b  output  WIDTH  registered operand B to shared multiplier
mul_product  input  WIDTH  multiplier result
resp_valid  output  NUM_REQ  one-hot, registered, 1-cycle pulse per completed op
resp_id  output  ID_W  index of requester owning resp_data
resp_data  output  WIDTH  registered product
inflight  output  ID_W+2  number of ops issued but not yet responded

Behaviour:
- Reset (async, rst=1): mul_a=0, mul_b=0, resp_valid=0, resp_id=0, resp_data=0, inflight=0, rr pointer=0, tag pipeline valid bits cleared. gnt is forced to 0 while rst=1.
- Arbitration (combinational):
  - Search req starting at index ptr, wrapping modulo NUM_REQ. The first set bit wins, and gnt is one-hot on that bit. If no request is set, gnt=0.
  - A request is accepted in any cycle where gnt[i]=1. There is no backpressure: the multiplier is fully pipelined, so a grant is always possible.
  - Requester holds req/operands until its gnt; after a grant it may deassert or present a new op next cycle.
- Pointer:
  - On the edge ending a grant cycle, ptr <= (winner+1) mod NUM_REQ.
  - No grant: ptr holds.
  - Wrap uses explicit compare, not power-of-two truncation, so NUM_REQ need not be a power of 2.
- Issue stage:
  - On a grant, mul_a/mul_b <= winner's operands, and the tag pipe stage 0 <= {1, winner id}.
  - No grant: mul_a/mul_b hold their previous value, and tag stage 0 valid <= 0.
- Tag pipeline:
  - MUL_LAT+1 stages of {valid, id}; shifts every cycle.
  - Last stage is aligned with mul_product being valid for that op.
- Response:
  - On the edge where the last tag stage is valid: resp_data <= mul_product, resp_id <= id, resp_valid <= onehot(id).
  - Otherwise resp_valid <= 0; resp_data and resp_id hold.
- Latency: grant in cycle n -> resp_valid high in cycle n+MUL_LAT+2. Throughput is 1 op/cycle.
- Ordering: responses leave in grant order. With back-to-back grants, responses are back-to-back.
- inflight counter:
  - +1 on a grant, -1 on a response, unchanged when both occur in the same cycle.
  - Maximum value is MUL_LAT+2 and it never wraps.
- Reset mid-operation:
  - All tag valids clear, so no resp_valid is produced for ops issued before reset. This holds even though the multiplier is not reset and mul_product may be stale.
  - Operation resumes on the first edge after rst falls, with ptr=0.
- Single requester continuously requesting: it is granted every cycle. The pointer still advances and still wraps back to it.

Test Plan:
- Single op: req=0001, req_a[0]=0x40000000 (2.0), req_b[0]=0x40400000 (3.0), MUL_LAT=1 -> gnt=0001 in cycle 0; resp_valid=0001, resp_id=0, resp_data=0x40C00000 in cycle 3; inflight 1,1,1,0.
- Round-robin: req=1111 held with all operands 0x3FC00000 (1.5) -> gnt sequence 0001,0010,0100,1000,0001; each resp_data=0x40100000 (2.25); resp_id sequence 0,1,2,3,0 on consecutive cycles starting cycle 3.
- Fairness after skip: ptr=2, req=0011 -> gnt=0001 (wraps past 2,3), next ptr=1.
- Mixed signs back-to-back: req0 0xC0000000×0x3F000000 then req1 0x40800000×0x40800000 -> resp 0xBF800000 (id0), then 0x41800000 (id1) on the next cycle.
- Reset mid-flight: grant two ops, assert rst for 1 cycle before either responds -> no resp_valid pulse at all, inflight=0, next grant goes to index 0 if requested.
- Idle gaps: requests every third cycle -> resp_valid pulses exactly every third cycle; resp_data/resp_id hold between pulses; inflight never exceeds 1.

Source files
------------

// File: rtl/fmul_share_arbiter.sv
// Round-robin front end that time-shares one pipelined FP multiplier between
// NUM_REQ requesters and routes each tagged product back to its owner.
module fmul_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int MUL_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [WIDTH-1:0]         mul_product,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W+1:0]          inflight
);

    localparam logic [ID_W:0]   NREQ    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [WIDTH-1:0] op_a [NUM_REQ];
    logic [WIDTH-1:0] op_b [NUM_REQ];

    logic [ID_W-1:0]             ptr_reg;
    logic [ID_W-1:0]             ptr_next;
    logic [ID_W-1:0]             win_id;
    logic                        found;
    logic [ID_W:0]               idx;
    logic [MUL_LAT:0]            tag_valid_reg;
    logic [MUL_LAT:0][ID_W-1:0]  tag_id_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from ptr with an explicit wrap so NUM_REQ need not be a power of two.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_reg} + k[ID_W:0];
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                win_id = idx[ID_W-1:0];
            end
        end
        if (rst) begin
            found = 1'b0;
        end
    end

    assign gnt      = found ? (NUM_REQ'(1) << win_id) : '0;
    assign ptr_next = (win_id == LAST_ID) ? '0 : win_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else if (found) begin
            ptr_reg <= ptr_next;
            mul_a   <= op_a[win_id];
            mul_b   <= op_b[win_id];
        end
    end

    // Tag pipe: last stage lines up with mul_product of the same op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            tag_valid_reg <= {tag_valid_reg[MUL_LAT-1:0], found};
            tag_id_reg    <= {tag_id_reg[MUL_LAT-1:0], win_id};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= '0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else if (tag_valid_reg[MUL_LAT]) begin
            resp_valid <= NUM_REQ'(1) << tag_id_reg[MUL_LAT];
            resp_id    <= tag_id_reg[MUL_LAT];
            resp_data  <= mul_product;
        end else begin
            resp_valid <= '0;
        end
    end

    // An op stays counted until its resp_valid pulse has been presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({found, |resp_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Scoreboard bench for fmul_share_arbiter with a one-stage multiplier stand-in.
module tb_fmul_share_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*WIDTH-1:0] req_a = '0;
    logic [NUM_REQ*WIDTH-1:0] req_b = '0;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [WIDTH-1:0]         mul_product = '0;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_data;
    logic [ID_W+1:0]          inflight;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    fmul_share_arbiter #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .inflight(inflight)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Normal-operand multiply, truncating; all vectors used are exact.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) return {s, 8'(e + 10'd1), p[46:24]};
        return {s, e[7:0], p[45:23]};
    endfunction

    always @(posedge clk) mul_product <= fmul(mul_a, mul_b);

    function automatic logic [ID_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) if (oh[i]) r = ID_W'(i);
        return r;
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // One cycle: drive req, check grant/inflight, queue the expected response.
    task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] eg,
                        input logic [31:0] ep, input int ei);
        exp_t e;
        req = r;
        @(negedge clk);
        checks++;
        if (gnt !== eg) begin
            errors++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg);
        end
        if (ei >= 0) begin
            checks++;
            if (inflight !== ei[ID_W+1:0]) begin
                errors++;
                $display("FAIL inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, ei);
            end
        end
        if (eg != '0) begin
            e.id   = oh2idx(eg);
            e.data = ep;
            e.cyc  = cyc;
            sb_q.push_back(e);
        end
        $display("cyc=%0d req=%b gnt=%b inflight=%0d", cyc, r, gnt, inflight);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops on every response pulse, checks hold value otherwise.
    initial begin : monitor
        exp_t            e;
        logic [WIDTH-1:0] last_data;
        logic [ID_W-1:0]  last_id;
        last_data = '0;
        last_id   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_data = '0;
                last_id   = '0;
            end else if (resp_valid != '0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp cyc=%0d got valid=%b id=%0d data=%h exp none",
                             cyc, resp_valid, resp_id, resp_data);
                end else begin
                    e = sb_q.pop_front();
                    if (resp_id !== e.id || resp_data !== e.data ||
                        resp_valid !== (NUM_REQ'(1) << e.id) || cyc != e.cyc + MUL_LAT + 2) begin
                        errors++;
                        $display("FAIL resp cyc=%0d got valid=%b id=%0d data=%h exp id=%0d data=%h cyc=%0d",
                                 cyc, resp_valid, resp_id, resp_data, e.id, e.data, e.cyc + MUL_LAT + 2);
                    end
                    $display("cyc=%0d resp id=%0d data=%h", cyc, resp_id, resp_data);
                    last_data = e.data;
                    last_id   = e.id;
                end
            end else begin
                checks++;
                if (resp_data !== last_data || resp_id !== last_id) begin
                    errors++;
                    $display("FAIL resp_hold cyc=%0d got id=%0d data=%h exp id=%0d data=%h",
                             cyc, resp_id, resp_data, last_id, last_data);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        do_reset();

        // Single op: 2.0 * 3.0
        set_op(0, 32'h40000000, 32'h40400000);
        step(4'b0001, 4'b0001, 32'h40C00000, 0);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 0);

        // Round robin, all 1.5 * 1.5
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h3FC00000, 32'h3FC00000);
        step(4'b1111, 4'b0001, 32'h40100000, 0);
        step(4'b1111, 4'b0010, 32'h40100000, 1);
        step(4'b1111, 4'b0100, 32'h40100000, 2);
        step(4'b1111, 4'b1000, 32'h40100000, 3);
        step(4'b1111, 4'b0001, 32'h40100000, 3);
        step(4'b0000, 4'b0000, 32'h0, 3);
        step(4'b0000, 4'b0000, 32'h0, 2);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 0);

        // Fairness after skip: get ptr to 2, then req=0011 wraps to 0
        do_reset();
        step(4'b0010, 4'b0010, 32'h40100000, 0);
        step(4'b0011, 4'b0001, 32'h40100000, 1);
        step(4'b0011, 4'b0010, 32'h40100000, 2);
        repeat (4) step(4'b0000, 4'b0000, 32'h0, -1);

        // Mixed signs back to back
        do_reset();
        set_op(0, 32'hC0000000, 32'h3F000000);
        set_op(1, 32'h40800000, 32'h40800000);
        step(4'b0011, 4'b0001, 32'hBF800000, 0);
        step(4'b0010, 4'b0010, 32'h41800000, 1);
        repeat (4) step(4'b0000, 4'b0000, 32'h0, -1);

        // Reset mid-flight: no response for the two killed ops
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h40000000, 32'h40400000);
        step(4'b0011, 4'b0001, 32'h40C00000, 0);
        step(4'b0011, 4'b0010, 32'h40C00000, 1);
        rst = 1'b1;
        sb_q.delete();
        req = 4'b1001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || inflight !== 4'd0) begin
            errors++;
            $display("FAIL reset_midflight got gnt=%b inflight=%0d exp gnt=0000 inflight=0", gnt, inflight);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b1001, 4'b0001, 32'h40C00000, 0);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 0);

        // Idle gaps: one request every third cycle, different owners/products
        do_reset();
        set_op(2, 32'h40000000, 32'h40000000);
        set_op(3, 32'h3F800000, 32'hC0400000);
        set_op(0, 32'h40A00000, 32'h3E800000);
        step(4'b0100, 4'b0100, 32'h40800000, 0);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b1000, 4'b1000, 32'hC0400000, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0001, 4'b0001, 32'h3FA00000, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 0);

        // Single requester held high is granted every cycle
        do_reset();
        step(4'b0100, 4'b0100, 32'h40800000, 0);
        step(4'b0100, 4'b0100, 32'h40800000, 1);
        step(4'b0100, 4'b0100, 32'h40800000, 2);
        step(4'b0000, 4'b0000, 32'h0, 3);
        step(4'b0000, 4'b0000, 32'h0, 2);
        step(4'b0000, 4'b0000, 32'h0, 1);
        step(4'b0000, 4'b0000, 32'h0, 0);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
